// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a shared 4:1 mux, with per-owner hold limit.
// Optional feature: define MUX_ARB_LOCK_EN to add the lock input (owner may extend its grant).
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       state,
  output logic [7:0] hold_cnt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_n;
  logic [3:0] gnt_q, gnt_n;
  logic [1:0] sel_q, sel_n;
  logic [1:0] last_q, last_n;
  logic [7:0] hold_q, hold_n;
  logic [2:0] pick;
  logic       owner_req;
  logic       lock_hold;

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Returns {found, index}; scans last+1 .. last+4 so the previous owner is considered last.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] i;
    r = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      i = last + 2'(k);
      if (!r[2] && cand[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  assign owner_req = |(req & gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      sel_q   <= sel_n;
      last_q  <= last_n;
      hold_q  <= hold_n;
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    last_n  = last_q;
    hold_n  = hold_q;
    pick    = 3'b000;
    case (state_q)
      IDLE: begin
        pick = rr_pick(req, last_q);
      end
      GRANT: begin
        if (!owner_req) begin
          // Owner released: it is masked out so only the others compete.
          pick = rr_pick(req & ~gnt_q, last_q);
          if (!pick[2]) begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            hold_n  = 8'd0;
          end
        end else if (hold_q < HOLD_LAST) begin
          hold_n = hold_q + 8'd1;
        end else if (!lock_hold) begin
          pick = rr_pick(req, last_q);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        hold_n  = 8'd0;
      end
    endcase
    if (pick[2]) begin
      state_n = GRANT;
      gnt_n   = 4'b0001 << pick[1:0];
      sel_n   = pick[1:0];
      last_n  = pick[1:0];
      hold_n  = 8'd0;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign busy     = |gnt_q;
  assign state    = state_q;
  assign hold_cnt = hold_q;

endmodule
